// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU operation scheduler.
//   - DEF_WIDTH : default operand/result width
//   - OP_*      : opcode encodings presented to the bitwise ALU
//   - state_e   : scheduler FSM state encoding
package alu_pkg;

    localparam int unsigned DEF_WIDTH = 3;
    localparam int unsigned OP_W      = 2;

    localparam logic [OP_W-1:0] OP_AND  = 2'b00;
    localparam logic [OP_W-1:0] OP_OR   = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
    localparam logic [OP_W-1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant.
//   i_valid[1:0]  : request lines from requester 1/0
//   i_last_grant  : requester served most recently (loses a tie)
//   o_grant[1:0]  : one-hot grant, all-zero when nothing is requested
module rr_arbiter2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // A lone request always wins; on a tie the requester not served last wins.
    assign o_grant[0] = i_valid[0] & (~i_valid[1] |  i_last_grant);
    assign o_grant[1] = i_valid[1] & (~i_valid[0] | ~i_last_grant);

endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: shares one registered bitwise ALU between two requesters.
// Accepts a command from either requester (round-robin on ties), holds the
// ALU inputs for LATENCY cycles, captures the result and returns it tagged
// with the requester id over a valid/ready response handshake.
//   clk, rst                      : clock, async active-high reset
//   req{0,1}_valid/_ready/_op/_a/_b : command handshakes (ready is combinational)
//   alu_op, alu_a, alu_b          : registered ALU inputs
//   alu_result                    : ALU output
//   rsp_valid/_ready/_data/_id    : response handshake
//   busy                          : high whenever the FSM is not idle
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_id,
    output logic              busy
);

    localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    if (LATENCY == 0) begin : g_latency_check
        $error("alu_op_scheduler: LATENCY must be at least 1");
    end

    state_e             r_state;
    logic               r_last_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [OP_W-1:0]    r_alu_op;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [WIDTH-1:0]   r_rsp_data;
    logic               r_rsp_id;
    logic               r_rsp_valid;
    logic               r_busy;

    logic [1:0]         w_grant;
    logic               w_idle;

    rr_arbiter2 u_arb (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Ready is only offered from IDLE and never while reset is held.
    assign w_idle     = (r_state == ST_IDLE) & ~rst;
    assign req0_ready = w_idle & w_grant[0];
    assign req1_ready = w_idle & w_grant[1];

    // Sequencer: grant -> hold ALU inputs -> capture -> respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant[1]) begin
                        r_alu_op <= req1_op;
                        r_alu_a  <= req1_a;
                        r_alu_b  <= req1_b;
                        r_rsp_id <= 1'b1;
                        r_cnt    <= CNT_W'(LATENCY);
                        r_busy   <= 1'b1;
                        r_state  <= ST_WAIT;
                    end else if (w_grant[0]) begin
                        r_alu_op <= req0_op;
                        r_alu_a  <= req0_a;
                        r_alu_b  <= req0_b;
                        r_rsp_id <= 1'b0;
                        r_cnt    <= CNT_W'(LATENCY);
                        r_busy   <= 1'b1;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Final wait cycle: the ALU output is valid now.
                    if (r_cnt == CNT_W'(1)) begin
                        r_rsp_data  <= alu_result;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_last_grant <= r_rsp_id;
                        r_rsp_valid  <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_valid = r_rsp_valid;
    assign busy      = r_busy;

endmodule
